// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
//   Shared definitions for the digit-serial adder/subtractor.
//   - state_t    : FSM state encoding (IDLE, RUN, DONE)
//   - width_ok   : elaboration-time check that DIGIT evenly divides WIDTH
//   - cnt_width  : digit counter width, $clog2(N) with a floor of one bit
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // True when the operand width splits into a whole number of digits.
  function automatic bit width_ok(input int w, input int d);
    return (d >= 1) && (d <= w) && ((w % d) == 0);
  endfunction

  // A single-digit configuration still needs a one-bit counter so the
  // counter declaration never collapses to a zero-width vector.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_adder_digit.sv
// -----------------------------------------------------------------------------
// FullAdder
//   One-bit full adder cell from the gate-level adder library.
//   Ports: a, b, cin (inputs); sum, cout (outputs).
//
// digit_adder
//   Combinational W-bit ripple chain of FullAdder cells.
//   Ports: a[W], b[W], cin (inputs); sum[W], cout, c_msb_in (outputs).
//   c_msb_in is the carry entering the top bit, needed by the caller to
//   form signed overflow as (carry into MSB) XOR (carry out of MSB).
// -----------------------------------------------------------------------------
module FullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module digit_adder #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb_in
);

  // c[i] is the carry entering bit i; c[W] leaves the chain.
  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_chain
    FullAdder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .sum (sum[i]),
      .cout(c[i+1])
    );
  end

  assign cout     = c[W];
  assign c_msb_in = c[W-1];

endmodule

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Digit-serial adder/subtractor. Each RUN cycle pushes DIGIT bits of both
//   operands through a narrow ripple chain, keeping the carry in a register
//   between digits. A result takes N = WIDTH/DIGIT cycles plus one DONE cycle.
//
//   Parameters: WIDTH (operand width), DIGIT (bits per cycle, divides WIDTH)
//   Ports:
//     clk, rst        clock and asynchronous active-high reset
//     start           request, accepted only while ready=1
//     sub             0: a+b+cin, 1: a-b (cin ignored)
//     a, b, cin       operands, sampled on the accepting edge
//     ready           high in IDLE
//     done            one-cycle pulse while the result is final
//     sum             result, held until the next accepted start
//     cout            carry out of the MSB (1 = no borrow when subtracting)
//     overflow        signed overflow of the full-width result
// -----------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  import serial_adder_pkg::*;

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  // Refuse to elaborate a configuration that leaves a partial top digit.
  if (!width_ok(WIDTH, DIGIT)) begin : g_width_check
    $error("serial_adder: WIDTH must be a non-zero multiple of DIGIT");
  end

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0] dsum;
  logic             dcout;
  logic             dcmsb;

  // The chain always sees the lowest digit of the operand registers; the
  // registers shift right each RUN cycle so the next digit moves into place.
  digit_adder #(
    .W(DIGIT)
  ) u_digit (
    .a       (opa[DIGIT-1:0]),
    .b       (opb[DIGIT-1:0]),
    .cin     (carry),
    .sum     (dsum),
    .cout    (dcout),
    .c_msb_in(dcmsb)
  );

  // Control FSM and datapath registers. Subtraction is folded into the
  // accept step: storing ~b with a carry-in of 1 turns a-b into a+~b+1, so
  // the RUN loop never needs to know which mode it is in. The result
  // register is cleared on accept and filled one digit at a time, which
  // keeps not-yet-computed digits reading as zero. Only the final digit's
  // carries describe the full-width result, so cout/overflow update there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      opa      <= '0;
      opb      <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      ready    <= 1'b1;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opa      <= a;
            opb      <= sub ? ~b : b;
            carry    <= sub ? 1'b1 : cin;
            cnt      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            ready    <= 1'b0;
            state    <= RUN;
          end
        end

        RUN: begin
          sum[int'(cnt) * DIGIT +: DIGIT] <= dsum;
          carry <= dcout;
          opa   <= opa >> DIGIT;
          opb   <= opb >> DIGIT;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            cout     <= dcout;
            overflow <= dcmsb ^ dcout;
            done     <= 1'b1;
            state    <= DONE;
          end
        end

        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//   Drives three serial_adder instances (DIGIT = 4, 1, 16 at WIDTH = 16) from
//   shared operand lines with a private start per instance. An arithmetic
//   model predicts ready/done/sum/cout/overflow for every cycle, and the
//   directed vectors additionally carry hand-computed results and latencies.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sub;
  logic        cin;
  logic [15:0] a;
  logic [15:0] b;

  logic        start    [3];
  logic        ready    [3];
  logic        done     [3];
  logic        cout     [3];
  logic        overflow [3];
  logic [15:0] sum      [3];

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int acceptCyc  = 0;

  // Model state: phase 0 is idle, 1..N are the RUN cycles, N+1 is DONE.
  int          phase [3] = '{0, 0, 0};
  logic [15:0] pend  [3];
  logic        pco   [3];
  logic        pov   [3];
  logic [15:0] hsum  [3] = '{16'h0, 16'h0, 16'h0};
  logic        hco   [3] = '{1'b0, 1'b0, 1'b0};
  logic        hov   [3] = '{1'b0, 1'b0, 1'b0};

  logic [16:0] mFull;
  logic [15:0] mB;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(16), .DIGIT(4)) dut4 (
    .clk(clk), .rst(rst), .start(start[0]), .sub(sub), .a(a), .b(b),
    .cin(cin), .ready(ready[0]), .done(done[0]), .sum(sum[0]),
    .cout(cout[0]), .overflow(overflow[0])
  );

  serial_adder #(.WIDTH(16), .DIGIT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .sub(sub), .a(a), .b(b),
    .cin(cin), .ready(ready[1]), .done(done[1]), .sum(sum[1]),
    .cout(cout[1]), .overflow(overflow[1])
  );

  serial_adder #(.WIDTH(16), .DIGIT(16)) dut16 (
    .clk(clk), .rst(rst), .start(start[2]), .sub(sub), .a(a), .b(b),
    .cin(cin), .ready(ready[2]), .done(done[2]), .sum(sum[2]),
    .cout(cout[2]), .overflow(overflow[2])
  );

  function automatic int digitsOf(input int inst);
    case (inst)
      0:       return 4;
      1:       return 16;
      default: return 1;
    endcase
  endfunction

  function automatic int digitBits(input int inst);
    case (inst)
      0:       return 4;
      1:       return 1;
      default: return 16;
    endcase
  endfunction

  task automatic compareValue(input string name, input logic [15:0] act,
                              input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: on each edge, decide acceptance from ready/start and
  // compute the whole result at once with plain 17-bit arithmetic. Signed
  // overflow comes from operand/result sign bits, not from internal carries.
  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        phase[i] = 0;
        hsum[i]  = 16'h0;
        hco[i]   = 1'b0;
        hov[i]   = 1'b0;
      end else if (phase[i] == 0) begin
        if (start[i]) begin
          mB      = sub ? ~b : b;
          mFull   = {1'b0, a} + {1'b0, mB} + (sub ? 17'd1 : {16'd0, cin});
          pend[i] = mFull[15:0];
          pco[i]  = mFull[16];
          pov[i]  = (a[15] == mB[15]) && (mFull[15] != a[15]);
          phase[i] = 1;
        end
      end else if (phase[i] == digitsOf(i) + 1) begin
        phase[i] = 0;
        hsum[i]  = pend[i];
        hco[i]   = pco[i];
        hov[i]   = pov[i];
      end else begin
        phase[i] = phase[i] + 1;
      end
    end
  end

  // Per-cycle comparison against the model on the falling edge. During RUN
  // only the digits committed so far may be non-zero, and they must already
  // equal the low bits of the final result.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      logic [15:0] eSum;
      logic        eReady, eDone, eCout, eOv;
      logic [31:0] mask;
      string       tag;
      tag = $sformatf("d%0d", digitBits(i));
      if (phase[i] == 0) begin
        eSum = hsum[i]; eCout = hco[i]; eOv = hov[i]; eReady = 1'b1; eDone = 1'b0;
      end else if (phase[i] == digitsOf(i) + 1) begin
        eSum = pend[i]; eCout = pco[i]; eOv = pov[i]; eReady = 1'b0; eDone = 1'b1;
      end else begin
        mask = (32'd1 << ((phase[i] - 1) * digitBits(i))) - 32'd1;
        eSum = pend[i] & mask[15:0]; eCout = 1'b0; eOv = 1'b0; eReady = 1'b0; eDone = 1'b0;
      end
      compareValue({tag, ".ready"},    {15'd0, ready[i]},    {15'd0, eReady});
      compareValue({tag, ".done"},     {15'd0, done[i]},     {15'd0, eDone});
      compareValue({tag, ".sum"},      sum[i],               eSum);
      compareValue({tag, ".cout"},     {15'd0, cout[i]},     {15'd0, eCout});
      compareValue({tag, ".overflow"}, {15'd0, overflow[i]}, {15'd0, eOv});
    end
  end

  // Wait for ready, then present one request for a single edge.
  task automatic applyStimulus(input int inst, input logic [15:0] av,
                               input logic [15:0] bv, input logic cv,
                               input logic sv);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready[inst] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!ready[inst]) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL ready_wait: got ready=0, expected ready=1 within 40 cycles");
    end
    #1;
    a = av; b = bv; cin = cv; sub = sv;
    start[inst] = 1'b1;
    @(posedge clk);
    #1;
    acceptCyc = cyc;
    start[inst] = 1'b0;
  endtask

  task automatic waitDone(input int inst, output int lat);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(posedge clk);
      #1;
      if (done[inst]) seen = 1'b1;
    end
    lat = cyc - acceptCyc;
    if (!seen) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL done_wait: got no done, expected done within 40 cycles");
    end
  endtask

  // Hand-computed expectations checked in the done cycle.
  task automatic checkOutput(input string name, input int inst,
                             input logic [15:0] eSum, input logic eCout,
                             input logic eOv, input int eLat);
    int lat;
    waitDone(inst, lat);
    compareValue({name, ".sum"},      sum[inst],               eSum);
    compareValue({name, ".cout"},     {15'd0, cout[inst]},     {15'd0, eCout});
    compareValue({name, ".overflow"}, {15'd0, overflow[inst]}, {15'd0, eOv});
    compareValue({name, ".latency"},  16'(lat),                16'(eLat));
  endtask

  // Directed vectors, mid-run start and reset abort, then a random sweep
  // over all three digit widths.
  initial begin
    int lat;
    for (int i = 0; i < 3; i++) start[i] = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    compareValue("reset.ready", {15'd0, ready[0]}, 16'd1);
    compareValue("reset.sum",   sum[0],            16'h0000);
    #1 rst = 1'b0;

    applyStimulus(0, 16'h1234, 16'h4321, 1'b0, 1'b0);
    checkOutput("add_basic", 0, 16'h5555, 1'b0, 1'b0, 4);
    applyStimulus(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    checkOutput("add_wrap", 0, 16'h0000, 1'b1, 1'b0, 4);
    applyStimulus(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    checkOutput("add_ovf", 0, 16'h8000, 1'b0, 1'b1, 4);
    applyStimulus(0, 16'h0005, 16'h0007, 1'b1, 1'b1);
    checkOutput("sub_borrow", 0, 16'hFFFE, 1'b0, 1'b0, 4);
    applyStimulus(0, 16'h8000, 16'h0001, 1'b0, 1'b1);
    checkOutput("sub_ovf", 0, 16'h7FFF, 1'b1, 1'b1, 4);

    // A second start while busy must be dropped without disturbing the op.
    applyStimulus(0, 16'h1111, 16'h2222, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    checkOutput("start_in_run", 0, 16'h3333, 1'b0, 1'b0, 4);

    // Abort partway through: reset rises before E2 and is held across it.
    applyStimulus(0, 16'h1234, 16'h1111, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    compareValue("abort.ready", {15'd0, ready[0]}, 16'd1);
    compareValue("abort.done",  {15'd0, done[0]},  16'd0);
    compareValue("abort.sum",   sum[0],            16'h0000);
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    applyStimulus(0, 16'h0F0F, 16'h00F1, 1'b1, 1'b0);
    checkOutput("after_abort", 0, 16'h1001, 1'b0, 1'b0, 4);

    applyStimulus(1, 16'hABCD, 16'h1234, 1'b1, 1'b0);
    checkOutput("bitserial", 1, 16'hBE02, 1'b0, 1'b0, 16);
    applyStimulus(2, 16'h8000, 16'h8000, 1'b0, 1'b0);
    checkOutput("fullwidth", 2, 16'h0000, 1'b1, 1'b1, 1);

    for (int inst = 0; inst < 3; inst++) begin
      for (int k = 0; k < 200; k++) begin
        applyStimulus(inst, 16'($urandom), 16'($urandom),
                      1'($urandom), 1'($urandom));
        waitDone(inst, lat);
        compareValue($sformatf("sweep_d%0d.latency", digitBits(inst)),
                     16'(lat), 16'(digitsOf(inst)));
      end
    end

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 2000000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Multi-cycle, parametrised adder/subtractor that processes `DIGIT` bits per clock through a registered carry, trading latency for a narrow `DIGIT`-bit full-adder chain. It is the sequential successor to the team's gate-level half/full-adder cells. It sits between operand registers and a result consumer and uses a start/done handshake.

## Interface

Parameters:
- `WIDTH`, 16: operand and result width in bits. Must be a multiple of `DIGIT`.
- `DIGIT`, 4: bits summed per cycle. Range 1..`WIDTH`.

Ports:
- `clk`  input  1: single clock. All state updates on the rising edge.
- `rst`  input  1: asynchronous, active-high reset.
- `start`  input  1: request. Accepted only on an edge where `ready`=1.
- `sub`  input  1: mode, sampled with `start`. 0 computes a+b+cin; 1 computes a−b (two's complement). `cin` is ignored when `sub`=1.
- `a`  input  `WIDTH`: operand A, sampled with `start`.
- `b`  input  `WIDTH`: operand B, sampled with `start`.
- `cin`  input  1: carry-in, sampled with `start`.
- `ready`  output  1: high in IDLE.
- `done`  output  1: one-cycle pulse; results are valid while it is high.
- `sum`  output  `WIDTH`: result. Held until the next accepted start.
- `cout`  output  1: carry out of the MSB. With `sub`=1, `cout`=1 means no borrow.
- `overflow`  output  1: signed overflow, computed as carry into MSB XOR carry out of MSB.

## Operation

- Digit count N = `WIDTH`/`DIGIT`.
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN when `start`=1.
  - RUN → DONE when the final digit is committed.
  - DONE → IDLE unconditionally.
- On accept:
  - latch `a` into the operand register.
  - latch `b`, or ~`b` when `sub`=1.
  - load the carry register with `cin`, or 1 when `sub`=1.
  - clear the digit counter, and clear `sum`, `cout` and `overflow`.
- Each RUN cycle:
  - add the low `DIGIT` bits of both operand registers plus the carry register.
  - write the `DIGIT`-bit result into the result register at digit index `cnt`, LSB digit first.
  - store the chain carry-out in the carry register.
  - shift both operand registers right by `DIGIT`, or index them by `cnt`; either is acceptable.
  - increment `cnt`.
- Final digit (`cnt`=N−1): `cout` takes the chain carry-out, and `overflow` takes the carry into bit `DIGIT`−1 XOR that carry-out.
- Arithmetic is modulo 2^`WIDTH`. No saturation.
- `start` while not in IDLE is ignored and not queued. Operands may change freely after acceptance.
- `DIGIT`=`WIDTH` is a legal degenerate case (N=1).

## Timing

- Reset values: state IDLE, `ready`=1, `done`=0, `sum`=0, `cout`=0, `overflow`=0, counter 0, carry 0.
- Reset asserted mid-operation aborts immediately. Outputs return to their reset values and there is no `done` pulse.
- Let the accept edge be E0. Digit k commits at edge E(k+1), so the last digit commits at EN.
- The cycle following EN:
  - `done`=1, `ready`=0.
  - `sum`, `cout` and `overflow` are final.
- At EN+1: `done`=0, `ready`=1. A new `start` can be accepted at edge EN+2 at the earliest.
- `ready` is low for N+1 cycles per operation. Throughput is one result per N+2 cycles.
- `sum` bits of uncommitted digits read 0 during RUN.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure

- Shared package/header holds:
  - FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - the width-check constant: elaboration fails if `WIDTH` % `DIGIT` ≠ 0.
- One sub-module, `digit_adder #(W)`: a combinational W-bit ripple chain of existing `FullAdder` instances. Its outputs are sum[W], cout, and c_msb_in (carry into the top bit).
- Counter width is $clog2(N), minimum 1.

## Test plan

- `WIDTH`=16, `DIGIT`=4: a=0x1234, b=0x4321, cin=0, sub=0 → `done` in the cycle after E4; sum=0x5555, cout=0, overflow=0.
- a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, overflow=0. Then a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, overflow=1.
- Subtraction, sub=1:
  - a=0x0005, b=0x0007, cin=1 (ignored) → sum=0xFFFE, cout=0.
  - a=0x8000, b=0x0001 → sum=0x7FFF, overflow=1.
- `start` pulsed during RUN with different operands → ignored. The first result stays intact and exactly one `done` pulse occurs.
- `rst` asserted at E2 of an operation → the next cycle shows `ready`=1, sum=0, no `done`. A new op then completes normally.
- Sweep `DIGIT`=1, 4, 16 at `WIDTH`=16 with 200 random operands vs a behavioural model. `done` occurs N=16, 4 and 1 cycles after accept respectively.
